muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit that produces the Hi/Lo results for MULT, MULTU, DIV and DIVU. It replaces the separate fixed-width multiplier and divider with one shared datapath. The unit uses a start/busy/done handshake with the control FSM and supports signed and unsigned modes. Hi/Lo are held internally; the top level routes them to the register-write mux and to the HI/LO registers.

---
 rtl/muldiv_unit.sv | 145 ++++++++++++++
 tb/tb_muldiv_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Shared iterative multiply/divide unit producing Hi/Lo for MULT, MULTU, DIV and DIVU.
// Works on operand magnitudes for WIDTH cycles, then applies signs and writes back in FIN.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             divZero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               isDiv_q;
  logic               negRes_q;
  logic               negRem_q;
  logic               zeroPend_q;
  logic               done_q;
  logic               divZero_q;
  logic [WIDTH-1:0]   opR_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               signA_d;
  logic               signB_d;
  logic [WIDTH-1:0]   magA_d;
  logic [WIDTH-1:0]   magB_d;
  logic [WIDTH:0]     mulSum_d;
  logic [2*WIDTH-1:0] mulNext_d;
  logic [WIDTH:0]     remShift_d;
  logic [WIDTH:0]     divDiff_d;
  logic [2*WIDTH-1:0] divNext_d;
  logic [2*WIDTH-1:0] product_d;
  logic [WIDTH-1:0]   quot_d;
  logic [WIDTH-1:0]   rem_d;

  // Operand magnitudes, one shift-add / shift-subtract step, and the final sign fix-up.
  always_comb begin
    signA_d    = ~op_i[0] & a_i[WIDTH-1];
    signB_d    = ~op_i[0] & b_i[WIDTH-1];
    magA_d     = signA_d ? -a_i : a_i;
    magB_d     = signB_d ? -b_i : b_i;

    mulSum_d   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opR_q} : '0);
    mulNext_d  = {mulSum_d, acc_q[WIDTH-1:1]};

    // Remainder lives in the upper half; quotient bits shift into the bottom.
    remShift_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    divDiff_d  = remShift_d - {1'b0, opR_q};
    if (divDiff_d[WIDTH]) begin
      divNext_d = {remShift_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      divNext_d = {divDiff_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    product_d  = negRes_q ? -acc_q : acc_q;
    quot_d     = negRes_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_d      = negRem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      isDiv_q    <= 1'b0;
      negRes_q   <= 1'b0;
      negRem_q   <= 1'b0;
      zeroPend_q <= 1'b0;
      done_q     <= 1'b0;
      divZero_q  <= 1'b0;
      opR_q      <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            isDiv_q   <= op_i[1];
            negRes_q  <= signA_d ^ signB_d;
            negRem_q  <= signA_d;
            divZero_q <= 1'b0;
            cnt_q     <= CW'(WIDTH);
            if (op_i[1]) begin
              acc_q <= {{WIDTH{1'b0}}, magA_d};
              opR_q <= magB_d;
            end else begin
              acc_q <= {{WIDTH{1'b0}}, magB_d};
              opR_q <= magA_d;
            end
            if (op_i[1] && (b_i == '0)) begin
              zeroPend_q <= 1'b1;
              state_q    <= FIN;
            end else begin
              zeroPend_q <= 1'b0;
              state_q    <= RUN;
            end
          end
        end
        RUN: begin
          acc_q <= isDiv_q ? divNext_d : mulNext_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
          // A divide by zero leaves Hi/Lo untouched and only raises the flag.
          if (zeroPend_q) begin
            divZero_q <= 1'b1;
          end else if (isDiv_q) begin
            hi_q <= rem_d;
            lo_q <= quot_d;
          end else begin
            hi_q <= product_d[2*WIDTH-1:WIDTH];
            lo_q <= product_d[WIDTH-1:0];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign divZero_o = divZero_q;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at WIDTH=32: expected Hi/Lo/DivZero and completion
// cycle are queued when an operation is launched and checked when Done pulses.
module tb_muldiv_unit;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          doneCycle;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, divZero;
  logic [31:0] hi, lo;

  exp_t        sbQ[$];
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;
  int          cycle = 0;
  int          vectors = 0;
  int          miscompares = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clock_i(clock), .reset_i(reset), .start_i(start), .op_i(op),
    .a_i(a), .b_i(b), .busy_o(busy), .done_o(done), .divZero_o(divZero),
    .hi_o(hi), .lo_o(lo)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Reference model: plain SystemVerilog arithmetic, plus the MIN/-1 and divide-by-zero rules.
  task automatic pushExpected(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                              input int doneCyc);
    exp_t        e;
    longint      sp;
    logic [63:0] p;
    int          sx, sy;
    e.dz = 1'b0;
    e.doneCycle = doneCyc;
    e.hi = '0;
    e.lo = '0;
    case (o)
      MULT: begin
        sp = longint'(int'(x)) * longint'(int'(y));
        p = sp;
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      MULTU: begin
        p = {32'b0, x} * {32'b0, y};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      DIV: begin
        if (y == 0) begin
          e.dz = 1'b1;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000;
          e.hi = 32'h0;
        end else begin
          sx = int'(x);
          sy = int'(y);
          e.lo = sx / sy;
          e.hi = sx % sy;
        end
      end
      default: begin
        if (y == 0) begin
          e.dz = 1'b1;
        end else begin
          e.lo = x / y;
          e.hi = x % y;
        end
      end
    endcase
    if (e.dz) begin
      e.hi = mHi;
      e.lo = mLo;
    end
    mHi = e.hi;
    mLo = e.lo;
    sbQ.push_back(e);
  endtask

  // Called just after a rising edge; waits for IDLE, launches one operation, returns after accept.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (busy) checkOutput("idleTimeout", {63'b0, busy}, 64'd0);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    pushExpected(o, x, y, cycle + 1 + ((o[1] && y == 0) ? 1 : 33));
    @(posedge clock); #1;
    start = 1'b0;
    checkOutput("busyAfterAccept", {63'b0, busy}, 64'd1);
    checkOutput("divZeroClearedOnAccept", {63'b0, divZero}, 64'd0);
  endtask

  // Scoreboard consumer: every Done pulse pops one entry and checks results and timing.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock); #1;
      if (done) begin
        if (sbQ.size() == 0) begin
          checkOutput("spuriousDone", 64'(sbQ.size()), 64'd1);
        end else begin
          e = sbQ.pop_front();
          checkOutput("hi", {32'b0, hi}, {32'b0, e.hi});
          checkOutput("lo", {32'b0, lo}, {32'b0, e.lo});
          checkOutput("divZero", {63'b0, divZero}, {63'b0, e.dz});
          checkOutput("doneCycle", 64'(cycle), 64'(e.doneCycle));
          checkOutput("busyLowAtDone", {63'b0, busy}, 64'd0);
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("rstBusy", {63'b0, busy}, 64'd0);
    checkOutput("rstDone", {63'b0, done}, 64'd0);
    checkOutput("rstDivZero", {63'b0, divZero}, 64'd0);
    checkOutput("rstHi", {32'b0, hi}, 64'd0);
    checkOutput("rstLo", {32'b0, lo}, 64'd0);

    // Signed multiply with mixed signs, plus busy duration.
    applyStimulus(MULT, 32'hFFFF_FFFD, 32'd7);
    n = 1;
    while (busy && n < 100) begin
      @(posedge clock); #1;
      if (busy) n++;
    end
    checkOutput("busyCycles", 64'(n), 64'd33);

    applyStimulus(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus(MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus(DIV, 32'hFFFF_FFF9, 32'd2);
    applyStimulus(DIVU, 32'd7, 32'd2);

    // Divide by zero keeps the preloaded Hi/Lo; the next accept clears the flag.
    applyStimulus(MULTU, 32'd5, 32'd6);
    applyStimulus(DIVU, 32'd7, 32'd0);
    applyStimulus(MULTU, 32'd2, 32'd3);
    applyStimulus(DIV, 32'd9, 32'd0);
    applyStimulus(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus(DIV, 32'd7, 32'hFFFF_FFFE);
    applyStimulus(DIVU, 32'h8000_0000, 32'h3);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), $urandom, (i == 5) ? 32'd0 : $urandom_range(1, 32'hFFFF_FFFF));
    end

    // Start pulsed mid-RUN must be ignored.
    applyStimulus(DIVU, 32'd100, 32'd7);
    repeat (5) begin @(posedge clock); #1; end
    start = 1'b1;
    op = MULTU;
    a = 32'd3;
    b = 32'd3;
    @(posedge clock); #1;
    start = 1'b0;

    // Start held high through the run is taken exactly in the Done cycle.
    applyStimulus(MULT, 32'd12345, 32'hFFFF_FFF7);
    start = 1'b1;
    op = DIVU;
    a = 32'd1000;
    b = 32'd33;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    if (!done) checkOutput("b2bDoneTimeout", {63'b0, done}, 64'd1);
    pushExpected(DIVU, 32'd1000, 32'd33, cycle + 1 + 33);
    @(posedge clock); #1;
    start = 1'b0;
    checkOutput("b2bBusy", {63'b0, busy}, 64'd1);

    // Reset in the middle of RUN aborts without write-back.
    applyStimulus(MULTU, 32'h0000_DEAD, 32'h0000_BEEF);
    repeat (9) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    sbQ.delete();
    mHi = '0;
    mLo = '0;
    checkOutput("abortBusy", {63'b0, busy}, 64'd0);
    checkOutput("abortDone", {63'b0, done}, 64'd0);
    checkOutput("abortHi", {32'b0, hi}, 64'd0);
    checkOutput("abortLo", {32'b0, lo}, 64'd0);
    applyStimulus(MULT, 32'hFFFF_FF00, 32'h0000_0100);

    n = 0;
    while (sbQ.size() != 0 && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput("drain", 64'(sbQ.size()), 64'd0);
    repeat (3) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
